load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 24 ++
 rtl/lsu_lane_align.sv | 40 ++++
 rtl/load_store_unit.sv | 128 ++++++++++++
 tb/tb_load_store_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states,
// RV32I load/store width codes and the default data-memory depth.
package lsu_pkg;

  localparam int MEM_WORDS_DEFAULT = 64;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/half lane handling: extract-and-extend for loads, and merge of a
// narrow store value into the surrounding memory word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] mem_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] lane_mask;

  always_comb begin
    shamt   = {byte_off, 3'b000};
    shifted = mem_word >> shamt;

    case (funct3)
      F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  load_data = {24'h0, shifted[7:0]};
      F3_LHU:  load_data = {16'h0, shifted[15:0]};
      default: load_data = mem_word;
    endcase

    case (funct3[1:0])
      2'b00:   lane_mask = 32'h0000_00FF;
      2'b01:   lane_mask = 32'h0000_FFFF;
      default: lane_mask = 32'hFFFF_FFFF;
    endcase

    // Untouched lanes come from memory, the written lane from the store data.
    merged_word = (mem_word & ~(lane_mask << shamt)) | ((store_data & lane_mask) << shamt);
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit over a single-port word memory; narrow stores are
// done as read-modify-write. Handshake: a request is taken on a rising clk
// edge where req_valid && req_ready; each request yields one resp_valid pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_write,
  output logic        mem_read,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  lsu_state_t  state_q, state_d;
  logic [31:0] addr_q, wdata_q, wr_word_q, rdata_q;
  logic [2:0]  f3_q;
  logic        we_q, err_q;
  logic        f3_ok, misalign, oob, req_err;
  logic [31:0] load_data, merged_word;

  always_comb begin
    case (req_funct3)
      F3_LB, F3_LH, F3_LW: f3_ok = 1'b1;
      F3_LBU, F3_LHU:      f3_ok = !req_we;
      default:             f3_ok = 1'b0;
    endcase
    misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
               ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    oob      = req_addr[31:2] >= 30'(MEM_WORDS);
    req_err  = !f3_ok || misalign || oob;
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)               state_d = RESP;
          else if (!req_we)          state_d = LOAD;
          else if (req_funct3 == F3_SW) state_d = WRITE;
          else                       state_d = RMW_RD;
        end
      end
      LOAD: begin
        mem_read = 1'b1;
        state_d  = RESP;
      end
      RMW_RD: begin
        mem_read = 1'b1;
        state_d  = WRITE;
      end
      WRITE: begin
        mem_write = 1'b1;
        state_d   = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_word_q <= '0;
      rdata_q   <= '0;
      f3_q      <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          addr_q    <= req_addr;
          f3_q      <= req_funct3;
          we_q      <= req_we;
          wdata_q   <= req_wdata;
          wr_word_q <= req_wdata;
          err_q     <= req_err;
        end
        LOAD:    rdata_q   <= load_data;
        RMW_RD:  wr_word_q <= merged_word;
        default: ;
      endcase
    end
  end

  lsu_lane_align u_align (
    .funct3      (f3_q),
    .byte_off    (addr_q[1:0]),
    .mem_word    (mem_read_data),
    .store_data  (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  // Memory-side outputs come only from registers so they hold steady under a strobe.
  assign mem_address    = {2'b00, addr_q[31:2]};
  assign mem_write_data = wr_word_q;
  assign resp_err       = resp_valid & err_q;
  assign resp_rdata     = (we_q || err_q) ? 32'h0 : rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random traffic checked
// against a byte-level reference model of the memory.
module tb_load_store_unit;

  localparam int MEM_WORDS = 64;
  localparam int AW = $clog2(MEM_WORDS);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];
  logic        mem_clear = 1'b1;

  logic [32:0] exp_q[$];
  logic [63:0] expw_q[$];

  int n_vec = 0;
  int n_bad = 0;

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  // ---------------- clock / memory model ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= 32'h0;
    end else if (mem_write && (mem_address < 32'(MEM_WORDS))) begin
      mem[mem_address[AW-1:0]] <= mem_write_data;
    end
  end

  assign mem_read_data = (mem_address < 32'(MEM_WORDS)) ? mem[mem_address[AW-1:0]] : 32'h0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      if (mem_read || mem_write) check_eq("strobe_excl", 64'(mem_read & mem_write), 64'd0);
      if (mem_write) begin
        if (expw_q.size() == 0) check_eq("spurious_write", 64'd1, 64'd0);
        else check_eq("write_word", {mem_address, mem_write_data}, expw_q.pop_front());
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) check_eq("spurious_resp", 64'd1, 64'd0);
        else check_eq("resp", 64'({resp_err, resp_rdata}), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- reference model ----------------
  // Works byte by byte on the model memory; pushes the expected response
  // and, for stores, the expected written word.
  task automatic ref_model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, output int lat, output int nrd, output int nwr);
    int size, idx, off;
    logic legal, err;
    logic [31:0] word, v, ones, bmask;
    ones = 32'hFFFF_FFFF;
    case (f3[1:0])
      2'd0: size = 1;
      2'd1: size = 2;
      2'd2: size = 4;
      default: size = 0;
    endcase
    legal = (size != 0) && (we ? !f3[2] : !(f3[2] && size == 4));
    err = !legal;
    if (legal && (addr % 32'(size)) != 0) err = 1'b1;
    if (addr >= 32'(4 * MEM_WORDS)) err = 1'b1;
    v = 32'h0;
    if (err) begin
      lat = 1; nrd = 0; nwr = 0;
    end else begin
      idx = int'(addr / 4);
      off = int'(addr % 4);
      word = ref_mem[idx];
      if (!we) begin
        for (int i = 0; i < size; i++) v = v | (((word >> (8 * (off + i))) & 32'hFF) << (8 * i));
        if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | (ones << (8 * size));
        lat = 2; nrd = 1; nwr = 0;
      end else begin
        for (int i = 0; i < size; i++) begin
          bmask = 32'hFF << (8 * (off + i));
          word = (word & ~bmask) | (((wd >> (8 * i)) & 32'hFF) << (8 * (off + i)));
        end
        ref_mem[idx] = word;
        expw_q.push_back({32'(idx), word});
        lat = (size == 4) ? 2 : 3;
        nrd = (size == 4) ? 0 : 1;
        nwr = 1;
      end
    end
    exp_q.push_back({err, v});
  endtask

  // ---------------- driver ----------------
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    int lat_e, nrd_e, nwr_e, lat, nrd, nwr;
    ref_model(we, f3, addr, wd, lat_e, nrd_e, nwr_e);
    @(negedge clk);
    check_eq("ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr = $urandom;
    lat = 1; nrd = 0; nwr = 0;
    forever begin
      if (mem_read) nrd++;
      if (mem_write) nwr++;
      if (resp_valid || lat >= 8) break;
      @(negedge clk);
      lat++;
    end
    check_eq("resp_seen", 64'(resp_valid), 64'd1);
    check_eq("latency", 64'(lat), 64'(lat_e));
    check_eq("n_reads", 64'(nrd), 64'(nrd_e));
    check_eq("n_writes", 64'(nwr), 64'(nwr_e));
  endtask

  task automatic rand_req();
    logic [2:0] f3;
    logic [31:0] addr;
    logic we;
    we = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 9) < 8) begin
      case ($urandom_range(0, 4))
        0: f3 = 3'b000;
        1: f3 = 3'b001;
        2: f3 = 3'b010;
        3: f3 = 3'b100;
        default: f3 = 3'b101;
      endcase
    end else begin
      f3 = 3'($urandom_range(0, 7));
    end
    addr = 32'($urandom_range(0, 4 * MEM_WORDS + 15));
    if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
    if ($urandom_range(0, 19) == 0) addr = $urandom;
    do_req(we, f3, addr, $urandom);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int wait_cnt;
    logic [2:0]  bb_f3 [3];
    logic        bb_we [3];
    logic [31:0] bb_addr [3];
    logic [31:0] bb_wd [3];
    int d0, d1, d2;

    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = 32'h0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 64'(req_ready), 64'd1);
    check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
    check_eq("rst_resp_err", 64'(resp_err), 64'd0);
    check_eq("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    check_eq("rst_mem_strobes", 64'({mem_read, mem_write}), 64'd0);
    check_eq("rst_mem_addr", 64'(mem_address), 64'd0);
    check_eq("rst_mem_wdata", 64'(mem_write_data), 64'd0);
    mem_clear = 1'b0;
    rst = 1'b1;

    // sign/zero extension of a byte
    do_req(1'b1, 3'b010, 32'h04, 32'h8899_AABB);
    do_req(1'b0, 3'b000, 32'h05, 32'h0);
    do_req(1'b0, 3'b100, 32'h05, 32'h0);
    // byte store read-modify-write
    do_req(1'b1, 3'b010, 32'h08, 32'h1122_3344);
    do_req(1'b1, 3'b000, 32'h0A, 32'h0000_00EE);
    do_req(1'b0, 3'b010, 32'h08, 32'h0);
    // half store then signed half load
    do_req(1'b1, 3'b010, 32'h0C, 32'h0);
    do_req(1'b1, 3'b001, 32'h0C, 32'h0000_BEEF);
    do_req(1'b0, 3'b001, 32'h0C, 32'h0);
    do_req(1'b0, 3'b101, 32'h0E, 32'h0);
    // faults: misaligned word, out of range, undefined width, misaligned half
    do_req(1'b0, 3'b010, 32'h06, 32'h0);
    do_req(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF);
    do_req(1'b0, 3'b011, 32'h10, 32'h0);
    do_req(1'b1, 3'b100, 32'h10, 32'h0);
    do_req(1'b1, 3'b001, 32'h0D, 32'h1234);
    do_req(1'b0, 3'b000, 32'hFF, 32'h0);

    // reset during the read half of a byte store
    do_req(1'b1, 3'b010, 32'h10, 32'h1234_5678);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h11; req_wdata = 32'h55;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("abort_in_rmw", 64'(mem_read), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort_ready", 64'(req_ready), 64'd1);
    check_eq("abort_no_write", 64'(mem_write), 64'd0);
    check_eq("abort_no_resp", 64'(resp_valid), 64'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    do_req(1'b0, 3'b010, 32'h10, 32'h0);

    // req_valid held high across LW, SW, LW
    bb_we[0] = 1'b0; bb_f3[0] = 3'b010; bb_addr[0] = 32'h10; bb_wd[0] = 32'h0;
    bb_we[1] = 1'b1; bb_f3[1] = 3'b010; bb_addr[1] = 32'h10; bb_wd[1] = 32'hCAFE_F00D;
    bb_we[2] = 1'b0; bb_f3[2] = 3'b010; bb_addr[2] = 32'h10; bb_wd[2] = 32'h0;
    for (int k = 0; k < 3; k++) ref_model(bb_we[k], bb_f3[k], bb_addr[k], bb_wd[k], d0, d1, d2);
    @(negedge clk);
    req_valid = 1'b1; req_we = bb_we[0]; req_funct3 = bb_f3[0]; req_addr = bb_addr[0]; req_wdata = bb_wd[0];
    for (int k = 0; k < 3; k++) begin
      wait_cnt = 0;
      while (!req_ready && wait_cnt < 10) begin
        @(negedge clk);
        wait_cnt++;
      end
      check_eq("b2b_accept", 64'(req_ready), 64'd1);
      @(posedge clk);
      #1;
      if (k < 2) begin
        req_we = bb_we[k+1]; req_funct3 = bb_f3[k+1]; req_addr = bb_addr[k+1]; req_wdata = bb_wd[k+1];
      end else begin
        req_valid = 1'b0;
      end
    end
    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    check_eq("b2b_drained", 64'(exp_q.size()), 64'd0);

    // random traffic
    for (int n = 0; n < 250; n++) rand_req();

    repeat (3) @(negedge clk);
    check_eq("exp_q_empty", 64'(exp_q.size()), 64'd0);
    check_eq("expw_q_empty", 64'(expw_q.size()), 64'd0);
    for (int i = 0; i < MEM_WORDS; i++) check_eq("final_mem", 64'(mem[i]), 64'(ref_mem[i]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
